// File: rtl/sensor_ctrl_core.sv
// Sensor controller datapath: captures sensor samples into a word buffer,
// raises a level interrupt when full, and serves registered buffer reads.
module sensor_ctrl_core #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic [ADDR_W-1:0] sctrl_addr,
  output logic [DATA_W-1:0] sctrl_out,
  output logic [ADDR_W:0]   sctrl_count,
  output logic              sctrl_interrupt,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sensor_en
);

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } state_e;

  localparam logic [ADDR_W:0] LastIdx  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DepthVal = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              full;
  logic              capture;

  assign full = (state_q == FULL);

  // Gating with rstn keeps the sensor request low for the whole reset window.
  assign sensor_en = rstn & sctrl_en & ~full & ~sctrl_clear;
  assign capture   = sensor_ready & sensor_en;

  assign sctrl_out       = out_q;
  assign sctrl_count     = count_q;
  assign sctrl_interrupt = irq_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    irq_d   = irq_q;
    if (sctrl_clear) begin
      state_d = FILLING;
      count_d = '0;
      irq_d   = 1'b0;
    end else if (capture) begin
      count_d = count_q + 1'b1;
      if (count_q == LastIdx) begin
        state_d = FULL;
        irq_d   = 1'b1;
      end
    end
  end

  // Words beyond DEPTH read as zero when the address space is larger than the buffer.
  always_comb begin
    out_d = '0;
    if ({1'b0, sctrl_addr} < DepthVal) begin
      out_d = mem[sctrl_addr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILLING;
      count_q <= '0;
      irq_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      irq_q   <= irq_d;
      out_q   <= out_d;
    end
  end

  // Buffer storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[count_q[ADDR_W-1:0]] <= sensor_out;
    end
  end

endmodule

// File: tb/tb_sensor_ctrl_core.sv
// Directed self-checking bench for sensor_ctrl_core: fill, full hold, clear,
// pause/resume, read-before-write and asynchronous reset mid-fill.
module tb_sensor_ctrl_core;

  localparam int DEPTH  = 64;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rstn;
  logic              sctrl_en;
  logic              sctrl_clear;
  logic [ADDR_W-1:0] sctrl_addr;
  logic [DATA_W-1:0] sctrl_out;
  logic [ADDR_W:0]   sctrl_count;
  logic              sctrl_interrupt;
  logic              sensor_ready;
  logic [DATA_W-1:0] sensor_out;
  logic              sensor_en;

  int compared   = 0;
  int mismatched = 0;

  sensor_ctrl_core #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sctrl_en       (sctrl_en),
    .sctrl_clear    (sctrl_clear),
    .sctrl_addr     (sctrl_addr),
    .sctrl_out      (sctrl_out),
    .sctrl_count    (sctrl_count),
    .sctrl_interrupt(sctrl_interrupt),
    .sensor_ready   (sensor_ready),
    .sensor_out     (sensor_out),
    .sensor_en      (sensor_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn         = 1'b0;
    sctrl_en     = 1'b1;
    sctrl_clear  = 1'b0;
    sctrl_addr   = '0;
    sensor_ready = 1'b0;
    sensor_out   = '0;
    #12;
    checkOutput("rst_count", 32'(sctrl_count), 32'd0);
    checkOutput("rst_irq", 32'(sctrl_interrupt), 32'd0);
    checkOutput("rst_out", sctrl_out, 32'd0);
    checkOutput("rst_sensor_en", 32'(sensor_en), 32'd0);
    rstn = 1'b1;
    #1;
    checkOutput("post_rst_sensor_en", 32'(sensor_en), 32'd1);

    // Fill all 64 words with 0x1000+i.
    $display("[TB] fill buffer");
    sensor_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      sensor_out = 32'h1000 + 32'(i);
      checkOutput("fill_sensor_en", 32'(sensor_en), 32'd1);
      checkOutput("fill_irq_low", 32'(sctrl_interrupt), 32'd0);
      applyStimulus();
      checkOutput("fill_count", 32'(sctrl_count), 32'(i + 1));
    end
    checkOutput("full_irq", 32'(sctrl_interrupt), 32'd1);
    checkOutput("full_sensor_en", 32'(sensor_en), 32'd0);

    // Full: further samples ignored.
    sensor_out = 32'hDEAD;
    for (int i = 0; i < 10; i++) applyStimulus();
    checkOutput("hold_count", 32'(sctrl_count), 32'd64);
    checkOutput("hold_irq", 32'(sctrl_interrupt), 32'd1);
    checkOutput("hold_sensor_en", 32'(sensor_en), 32'd0);

    // Reads with 1-cycle latency.
    sctrl_addr = 6'd0;
    applyStimulus();
    checkOutput("rd_0", sctrl_out, 32'h1000);
    sctrl_addr = 6'd1;
    applyStimulus();
    checkOutput("rd_1", sctrl_out, 32'h1001);
    sctrl_addr = 6'd31;
    applyStimulus();
    checkOutput("rd_31", sctrl_out, 32'h101F);
    sctrl_addr = 6'd63;
    checkOutput("rd_63_latency", sctrl_out, 32'h101F);
    applyStimulus();
    checkOutput("rd_63", sctrl_out, 32'h103F);

    // Clear at full; sensor_en is masked while the strobe is high.
    $display("[TB] clear");
    sensor_ready = 1'b0;
    sctrl_clear  = 1'b1;
    #1;
    checkOutput("clear_sensor_en_low", 32'(sensor_en), 32'd0);
    applyStimulus();
    sctrl_clear = 1'b0;
    #1;
    checkOutput("clear_count", 32'(sctrl_count), 32'd0);
    checkOutput("clear_irq", 32'(sctrl_interrupt), 32'd0);
    checkOutput("clear_sensor_en", 32'(sensor_en), 32'd1);

    // Refill indices 0..4 with 0xA0+i.
    sensor_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sensor_out = 32'hA0 + 32'(i);
      applyStimulus();
    end
    checkOutput("refill_count5", 32'(sctrl_count), 32'd5);

    // Read and capture index 5 together: old contents come back first.
    sctrl_addr = 6'd5;
    sensor_out = 32'h2005;
    applyStimulus();
    checkOutput("rbw_old", sctrl_out, 32'h1005);
    sensor_ready = 1'b0;
    applyStimulus();
    checkOutput("rbw_new", sctrl_out, 32'h2005);
    checkOutput("rbw_count", 32'(sctrl_count), 32'd6);

    sensor_ready = 1'b1;
    for (int i = 6; i < 20; i++) begin
      sensor_out = 32'hA0 + 32'(i);
      applyStimulus();
    end
    checkOutput("refill_count20", 32'(sctrl_count), 32'd20);

    // Pause with sctrl_en low.
    $display("[TB] pause and resume");
    sctrl_en   = 1'b0;
    sensor_out = 32'hBAD0;
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("pause_count", 32'(sctrl_count), 32'd20);
    checkOutput("pause_sensor_en", 32'(sensor_en), 32'd0);
    sctrl_en   = 1'b1;
    sensor_out = 32'hBEEF;
    applyStimulus();
    checkOutput("resume_count", 32'(sctrl_count), 32'd21);
    sensor_ready = 1'b0;
    sctrl_addr   = 6'd20;
    applyStimulus();
    checkOutput("resume_rd_20", sctrl_out, 32'hBEEF);
    sctrl_addr = 6'd19;
    applyStimulus();
    checkOutput("resume_rd_19", sctrl_out, 32'hB3);
    sctrl_addr = 6'd0;
    applyStimulus();
    checkOutput("resume_rd_0", sctrl_out, 32'hA0);

    // Advance to count 30, then assert reset between edges.
    sensor_ready = 1'b1;
    for (int i = 21; i < 30; i++) begin
      sensor_out = 32'hC0 + 32'(i);
      applyStimulus();
    end
    checkOutput("pre_rst_count", 32'(sctrl_count), 32'd30);
    checkOutput("pre_rst_out", sctrl_out, 32'hA0);
    $display("[TB] async reset mid-fill");
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_sensor_en", 32'(sensor_en), 32'd0);
    checkOutput("async_rst_irq", 32'(sctrl_interrupt), 32'd0);
    checkOutput("async_rst_out", sctrl_out, 32'd0);
    checkOutput("async_rst_count", 32'(sctrl_count), 32'd0);
    applyStimulus();
    checkOutput("in_rst_count", 32'(sctrl_count), 32'd0);
    rstn       = 1'b1;
    sensor_out = 32'h5555;
    applyStimulus();
    checkOutput("restart_count", 32'(sctrl_count), 32'd1);
    sensor_ready = 1'b0;
    sctrl_addr   = 6'd0;
    applyStimulus();
    checkOutput("restart_rd_0", sctrl_out, 32'h5555);
    sctrl_addr = 6'd1;
    applyStimulus();
    checkOutput("restart_rd_1_old", sctrl_out, 32'hA1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sensor_ctrl_core.md
Name: sensor_ctrl_core

Overview:
Datapath core of the sensor controller. It sits between the external sensor pins (sensor_en, sensor_ready, sensor_out) and the AXI-slave register front-end of the sensor controller.
- Captures sensor samples into a DEPTH-word buffer.
- Raises an interrupt to the CPU when the buffer is full.
- Provides a registered read port so the front-end can return buffer words on AXI reads.
- The CPU acknowledges via a clear strobe, which re-arms capture.

Parameters:
DEPTH, 64, number of 32-bit sample words in the buffer
DATA_W, 32, sample width
ADDR_W, 6, buffer read-address width; must equal $clog2(DEPTH)

Ports:
clk  in  1  core clock; all state updates on rising edge
rstn  in  1  reset; asynchronous, active-low
sctrl_en  in  1  capture enable from front-end control register (level)
sctrl_clear  in  1  single-cycle strobe: empty the buffer and drop the interrupt
sctrl_addr  in  ADDR_W  buffer word index for reads
sctrl_out  out  DATA_W  read data for sctrl_addr, registered
sctrl_count  out  ADDR_W+1  number of valid samples held (0..DEPTH)
sctrl_interrupt  out  1  buffer-full interrupt, registered level
sensor_ready  in  1  sensor presents a valid sample this cycle
sensor_out  in  DATA_W  sample data
sensor_en  out  1  request samples from the sensor

Behaviour:
- Reset (rstn low, asynchronous):
  - count=0, full=0, sctrl_interrupt=0, sctrl_out=0.
  - Buffer contents are not reset; reads of unwritten words are undefined.
- State: FILLING (count<DEPTH) and FULL (count==DEPTH). full is a register equal to (count==DEPTH).
- sensor_en is combinational: sctrl_en & ~full & ~sctrl_clear. It is 0 during reset.
- Capture: at a rising edge where sensor_ready & sensor_en:
  - mem[count] <= sensor_out.
  - count <= count+1.
  - sensor_ready while sensor_en=0 is ignored; no write, no count change.
- FILLING->FULL: on the capture that makes count==DEPTH.
  - On that same edge, full<=1 and sctrl_interrupt<=1, so both are visible 1 cycle after the last sample.
  - sensor_en drops in the same cycle that full rises.
- FULL: no captures. sctrl_interrupt holds 1 until a clear arrives, regardless of sctrl_en.
- Clear: an edge with sctrl_clear=1 sets count<=0, full<=0, sctrl_interrupt<=0.
  - Clear wins over a capture in the same cycle; no capture can occur anyway, because sensor_en=0 while clear is high.
  - Clear while FILLING discards the partial fill.
  - Clear while sctrl_en=0 is legal.
- sctrl_en deasserted mid-fill: capture pauses; count and data are retained; capture resumes at the same index when sctrl_en returns.
- Read port:
  - sctrl_out <= mem[sctrl_addr] on every rising edge; latency 1 cycle.
  - Read and capture to the same index in the same cycle returns the old contents (read-before-write).
  - If DEPTH < 2**ADDR_W and sctrl_addr >= DEPTH, sctrl_out <= 0.
- sctrl_count mirrors the count register. Width ADDR_W+1, so DEPTH is representable with no wrap.
- count never exceeds DEPTH; there is no wrap-around.
- Reset asserted mid-fill: immediately returns to the reset state; sensor_en goes 0 asynchronously.

Test Plan:
1. Reset, then sctrl_en=1, sensor_ready=1 for 64 cycles with sensor_out=0x1000+i -> sctrl_count steps 1..64; sensor_en falls in the cycle full rises; sctrl_interrupt=1 one cycle after the 64th capture; reading addr k returns 0x1000+k with 1-cycle latency.
2. Buffer full, sensor_ready held 1 for 10 more cycles with sensor_out=0xDEAD -> no writes; addr 0 still reads 0x1000; count stays 64; interrupt stays 1.
3. Pulse sctrl_clear at full -> next edge count=0, interrupt=0, sensor_en=1 again; new samples 0xA0.. land at index 0 onward.
4. Fill 20 samples, drop sctrl_en for 5 cycles with sensor_ready=1 -> count stays 20; re-enable and the next sample lands at index 20.
5. sctrl_addr=5 in the same cycle as the capture into index 5 (old 0x1005, new 0x2005) -> sctrl_out=0x1005 next cycle, 0x2005 on the following read.
6. Pull rstn low at count=30 -> sensor_en, sctrl_interrupt, sctrl_out, sctrl_count all 0 immediately; after release, capture restarts at index 0.
